// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: FETCH -> DECODE -> EXEC -> WB, with BRZ and HALT.
// Optional single-step fetch gating is enabled by defining SEQ_SINGLE_STEP_EN.
module control_sequencer #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            reset,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic            step,
`endif
  input  logic [15:0]     instr,
  input  logic            instr_valid,
  input  logic            zero,
  output logic [PC_W-1:0] pc,
  output logic            instr_req,
  output logic [3:0]      DA,
  output logic [3:0]      AA,
  output logic [3:0]      BA,
  output logic [3:0]      FS,
  output logic            RW,
  output logic            MB,
  output logic [15:0]     const_out,
  output logic            halted
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_WB     = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam logic [3:0] OP_LDI  = 4'b1101;
  localparam logic [3:0] OP_BRZ  = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [3:0]      da_q, da_d, aa_q, aa_d, ba_q, ba_d, fs_q, fs_d;
  logic            mb_q, mb_d;
  logic [15:0]     const_q, const_d;
  logic            rw_q, rw_d;
  logic            req_q, req_d;
  logic            halted_q, halted_d;
  logic            pend_d;
  logic            accept;

  logic [3:0]      ir_op;
  logic [3:0]      dec_fs;
  logic            dec_mb;
  logic [PC_W-1:0] br_off;

  assign ir_op  = ir_q[15:12];
  assign dec_fs = (ir_op <= 4'b1100) ? ir_op : 4'b0000;
  assign dec_mb = (ir_op == OP_LDI);

  // Sign-extend the 4-bit branch offset to the PC width.
  for (genvar gi = 0; gi < PC_W; gi++) begin : g_br_off
    assign br_off[gi] = ir_q[(gi < 4) ? gi : 3];
  end

`ifdef SEQ_SINGLE_STEP_EN
  logic pend_q;

  always_comb begin
    pend_d = pend_q;
    if (accept) pend_d = 1'b0;
    if (step)   pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pend_q <= 1'b0;
    else        pend_q <= pend_d;
  end
`else
  assign pend_d = 1'b1;
`endif

  assign accept = (state_q == S_FETCH) && req_q && instr_valid;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    da_d    = da_q;
    aa_d    = aa_q;
    ba_d    = ba_q;
    fs_d    = fs_q;
    mb_d    = mb_q;
    const_d = const_q;
    case (state_q)
      S_FETCH: begin
        if (accept) begin
          ir_d    = instr;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Decoded fields are captured here so they hold through EXEC/WB and beyond.
        da_d    = ir_q[11:8];
        aa_d    = ir_q[7:4];
        ba_d    = ir_q[3:0];
        fs_d    = dec_fs;
        mb_d    = dec_mb;
        const_d = {12'b0, ir_q[3:0]};
        state_d = (ir_op == OP_HALT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        if (ir_op == OP_BRZ) begin
          if (zero) pc_d = pc_q + br_off;
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  assign rw_d     = (state_d == S_WB);
  assign halted_d = (state_d == S_HALT);
  assign req_d    = (state_d == S_FETCH) && pend_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      da_q     <= '0;
      aa_q     <= '0;
      ba_q     <= '0;
      fs_q     <= '0;
      mb_q     <= 1'b0;
      const_q  <= '0;
      rw_q     <= 1'b0;
      req_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      da_q     <= da_d;
      aa_q     <= aa_d;
      ba_q     <= ba_d;
      fs_q     <= fs_d;
      mb_q     <= mb_d;
      const_q  <= const_d;
      rw_q     <= rw_d;
      req_q    <= req_d;
      halted_q <= halted_d;
    end
  end

  // During DECODE the fields come straight from IR; otherwise the held copies.
  assign DA        = (state_q == S_DECODE) ? ir_q[11:8] : da_q;
  assign AA        = (state_q == S_DECODE) ? ir_q[7:4]  : aa_q;
  assign BA        = (state_q == S_DECODE) ? ir_q[3:0]  : ba_q;
  assign FS        = (state_q == S_DECODE) ? dec_fs     : fs_q;
  assign MB        = (state_q == S_DECODE) ? dec_mb     : mb_q;
  assign const_out = (state_q == S_DECODE) ? {12'b0, ir_q[3:0]} : const_q;

  assign pc        = pc_q;
  assign instr_req = req_q;
  assign RW        = rw_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer; expected write-back fields are queued at fetch
// and compared when RW pulses.
module tb_control_sequencer;
  localparam int PC_W = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [15:0]     instr = 16'h0;
  logic            instr_valid = 1'b0;
  logic            zero = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
  logic            step = 1'b0;
`endif
  logic [PC_W-1:0] pc;
  logic            instr_req;
  logic [3:0]      DA, AA, BA, FS;
  logic            RW, MB;
  logic [15:0]     const_out;
  logic            halted;

  control_sequencer #(.PC_W(PC_W)) dut (
    .clk(clk),
    .reset(reset),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .instr(instr),
    .instr_valid(instr_valid),
    .zero(zero),
    .pc(pc),
    .instr_req(instr_req),
    .DA(DA),
    .AA(AA),
    .BA(BA),
    .FS(FS),
    .RW(RW),
    .MB(MB),
    .const_out(const_out),
    .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  da;
    logic [3:0]  aa;
    logic [3:0]  ba;
    logic [3:0]  fs;
    logic        mb;
    logic [15:0] cst;
  } exp_t;

  exp_t            sb[$];
  int              tests = 0;
  int              fails = 0;
  logic [PC_W-1:0] pc_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] ins);
    exp_t e;
    e.da  = ins[11:8];
    e.aa  = ins[7:4];
    e.ba  = ins[3:0];
    e.fs  = (ins[15:12] <= 4'd12) ? ins[15:12] : 4'd0;
    e.mb  = (ins[15:12] == 4'd13);
    e.cst = {12'h000, ins[3:0]};
    return e;
  endfunction

  task automatic wait_req();
    int n = 0;
`ifdef SEQ_SINGLE_STEP_EN
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
`endif
    while (instr_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_wait", {31'b0, instr_req}, 32'd1);
  endtask

  // Returns at the negedge of the DECODE cycle.
  task automatic fetch(input logic [15:0] ins);
    wait_req();
    instr = ins;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    instr = 16'h0;
    pc_m = pc_m + 1'b1;
    check("pc_fetch", 32'(pc), 32'(pc_m));
  endtask

  task automatic run_wr(input logic [15:0] ins);
    int n = 0;
    exp_t e;
    fetch(ins);
    sb.push_back(model(ins));
    while (RW !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("wb_latency", 32'(n), 32'd2);
    e = sb.pop_front();
    check("wb_da", 32'(DA), 32'(e.da));
    check("wb_aa", 32'(AA), 32'(e.aa));
    check("wb_ba", 32'(BA), 32'(e.ba));
    check("wb_fs", 32'(FS), 32'(e.fs));
    check("wb_mb", 32'(MB), 32'(e.mb));
    check("wb_const", 32'(const_out), 32'(e.cst));
    @(negedge clk);
    check("rw_pulse", 32'(RW), 32'd0);
    check("hold_da_fetch", 32'(DA), 32'(e.da));
  endtask

  task automatic run_brz(input logic [15:0] ins, input logic z);
    int rw_seen = 0;
    logic [PC_W-1:0] off;
    off = {{(PC_W-4){ins[3]}}, ins[3:0]};
    zero = z;
    fetch(ins);
    if (RW) rw_seen++;
    repeat (2) begin
      @(negedge clk);
      if (RW) rw_seen++;
    end
    if (z) pc_m = pc_m + off;
    check("brz_pc", 32'(pc), 32'(pc_m));
    check("brz_no_rw", 32'(rw_seen), 32'd0);
    check("brz_back_to_fetch", 32'(instr_req), 32'd1);
    zero = 1'b0;
  endtask

  initial begin
    exp_t e;
    logic [PC_W-1:0] pc_hold;
    pc_m = '0;

    #12;
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_req", 32'(instr_req), 32'd0);
    check("rst_rw", 32'(RW), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_da", 32'(DA), 32'd0);
    check("rst_fs", 32'(FS), 32'd0);
    check("rst_mb", 32'(MB), 32'd0);
    check("rst_const", 32'(const_out), 32'd0);

    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
`ifndef SEQ_SINGLE_STEP_EN
    check("req_after_reset", 32'(instr_req), 32'd1);
`endif
    @(negedge clk);

    run_wr(16'hD35A);
    check("ldi_pc", 32'(pc), 32'd1);
    fetch(16'h2123);
    check("dec_fs", 32'(FS), 32'd2);
    check("dec_aa", 32'(AA), 32'd2);
    @(negedge clk);
    @(negedge clk);
    check("alu2_rw", 32'(RW), 32'd1);
    check("alu2_da", 32'(DA), 32'd1);
    @(negedge clk);
    check("alu2_rw_off", 32'(RW), 32'd0);
    run_wr(16'h0456);
    run_wr(16'hC789);
    run_wr(16'h1ABC);
    check("pc_five", 32'(pc), 32'd5);

    run_brz(16'hE01E, 1'b1);
    check("brz_taken_pc4", 32'(pc), 32'd4);
    run_wr(16'h3111);
    run_brz(16'hE01E, 1'b0);
    check("brz_not_taken_pc6", 32'(pc), 32'd6);
    run_brz(16'hE01F, 1'b1);
    check("brz_minus1_pc6", 32'(pc), 32'd6);

    wait_req();
    pc_hold = pc;
    repeat (5) begin
      @(negedge clk);
      check("idle_req", 32'(instr_req), 32'd1);
      check("idle_pc", 32'(pc), 32'(pc_hold));
    end

    fetch(16'h5321);
    sb.push_back(model(16'h5321));
    instr = 16'hDFFF;
    instr_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    instr = 16'h0;
    check("ign_rw", 32'(RW), 32'd1);
    e = sb.pop_front();
    check("ign_da", 32'(DA), 32'(e.da));
    check("ign_fs", 32'(FS), 32'(e.fs));
    @(negedge clk);
    check("ign_pc", 32'(pc), 32'(pc_m));

    fetch(16'h6777);
    @(negedge clk);
    @(negedge clk);
    check("abort_rw_before", 32'(RW), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("abort_rw", 32'(RW), 32'd0);
    check("abort_pc", 32'(pc), 32'd0);
    check("abort_req", 32'(instr_req), 32'd0);
    check("abort_da", 32'(DA), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    pc_m = '0;
    @(negedge clk);
    check("abort_no_write", 32'(RW), 32'd0);
    run_wr(16'h2123);

    run_brz(16'hE008, 1'b1);
    check("wrap_pc_fa", 32'(pc), 32'hFA);
    repeat (6) run_wr(16'h0000);
    check("wrap_pc_zero", 32'(pc), 32'd0);

    fetch(16'hF000);
    @(negedge clk);
    repeat (20) begin
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_req", 32'(instr_req), 32'd0);
      check("halt_rw", 32'(RW), 32'd0);
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    check("unhalt_pc", 32'(pc), 32'd0);
    check("unhalt_flag", 32'(halted), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    pc_m = '0;

`ifdef SEQ_SINGLE_STEP_EN
    begin
      int rw_cnt = 0;
      instr = 16'h2123;
      instr_valid = 1'b1;
      repeat (10) begin
        @(negedge clk);
        check("step_idle_req", 32'(instr_req), 32'd0);
      end
      check("step_idle_pc", 32'(pc), 32'd0);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      repeat (20) begin
        @(negedge clk);
        if (RW) rw_cnt++;
      end
      instr_valid = 1'b0;
      check("step_one_write", 32'(rw_cnt), 32'd1);
      check("step_one_pc", 32'(pc), 32'd1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
